axi_stream_wr_master: RTL and testbench

- AXI4 write master that takes a {start address, beat count} command and an AXI-Stream data input.
- Writes the stream to memory as INCR bursts; sits directly upstream of the team's AXI4 RAM/memory slaves.
- Splits each transfer into bursts of at most MAX_BURST beats and never crosses a 4 KB boundary.
- One burst outstanding at a time; reports completion and error status per command.

---
 rtl/axi_stream_wr_master_pkg.sv | 37 +++
 rtl/axi_burst_splitter.sv | 37 +++
 rtl/axi_stream_wr_master.sv | 196 +++++++++++++++++++
 tb/tb_axi_stream_wr_master.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_wr_master_pkg.sv
// rtl/axi_stream_wr_master_pkg.sv - shared AXI constants, FSM states and helpers for the stream write master
package axi_stream_wr_master_pkg;

  // AXI burst types
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Bursts may never cross a 4 KB page
  localparam int AXI_BOUNDARY_4K   = 4096;
  localparam int AXI_BOUNDARY_BITS = 12;

  // Largest burst length the AXI4 AWLEN field can express, in beats
  localparam int AXI_MAX_BEATS = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_t;

  // Ceiling log2; clogb2(1) = 0
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_splitter.sv
// rtl/axi_burst_splitter.sv - beats in the next INCR burst: min(remaining, MAX_BURST, beats left in the 4 KB page)
module axi_burst_splitter
  import axi_stream_wr_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int REM_WIDTH  = 17
) (
  input  logic [AXI_BOUNDARY_BITS-1:0] i_page_off,
  input  logic [REM_WIDTH-1:0]         i_remaining,
  output logic [8:0]                   o_beats
);

  localparam int SIZE_LOG  = clogb2(DATA_WIDTH / 8);
  localparam int PAGE_W    = AXI_BOUNDARY_BITS + 1;
  localparam int CMP_WIDTH = (REM_WIDTH > 9) ? REM_WIDTH : 9;

  // Beats that still fit before the next 4 KB page; the offset is beat aligned,
  // so the shift is exact. A page-aligned address yields the full page.
  logic [PAGE_W-1:0] w_to_boundary;
  // Cap from the page boundary and the configured burst limit; never above 256
  logic [8:0]        w_cap;
  // Remaining and cap compared in a common width so narrow LEN_WIDTH still works
  logic [CMP_WIDTH-1:0] w_rem_ext;
  logic [CMP_WIDTH-1:0] w_cap_ext;

  assign w_to_boundary = (PAGE_W'(AXI_BOUNDARY_4K) - {1'b0, i_page_off}) >> SIZE_LOG;

  assign w_cap = (w_to_boundary < PAGE_W'(MAX_BURST)) ? w_to_boundary[8:0]
                                                      : 9'(MAX_BURST);

  assign w_rem_ext = CMP_WIDTH'(i_remaining);
  assign w_cap_ext = CMP_WIDTH'(w_cap);

  assign o_beats = (w_rem_ext < w_cap_ext) ? w_rem_ext[8:0] : w_cap;

endmodule

// File: rtl/axi_stream_wr_master.sv
// rtl/axi_stream_wr_master.sv - AXI4 write master turning {addr, len} commands plus a stream into INCR bursts
module axi_stream_wr_master
  import axi_stream_wr_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  // stream in
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  // AXI write address
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // status
  output logic                    done,
  output logic                    error
);

  localparam int BPB       = DATA_WIDTH / 8;
  localparam int SIZE_LOG  = clogb2(BPB);
  localparam int REM_WIDTH = LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LSB_MASK = ADDR_WIDTH'(BPB - 1);

  wr_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;       // start address of the current/next burst
  logic [REM_WIDTH-1:0]  r_remaining;  // beats not yet covered by a completed burst
  logic [8:0]            r_beats;      // beats in the current burst
  logic [7:0]            r_awlen;
  logic [7:0]            r_cnt;        // beats left in the burst minus one
  logic                  r_awvalid;
  logic                  r_bready;
  logic                  r_cmd_ready;
  logic                  r_done;
  logic                  r_error;

  logic [ADDR_WIDTH-1:0] w_cmd_addr_al;
  logic [REM_WIDTH-1:0]  w_cmd_rem;
  logic [AXI_BOUNDARY_BITS-1:0] w_split_page;
  logic [REM_WIDTH-1:0]  w_split_rem;
  logic [8:0]            w_beats;
  logic [ADDR_WIDTH-1:0] w_addr_step;
  logic                  w_in_data;
  logic                  w_w_fire;
  logic                  w_unused;

  assign w_cmd_addr_al = cmd_addr & ~ADDR_LSB_MASK;
  assign w_cmd_rem     = REM_WIDTH'(cmd_len) + REM_WIDTH'(1);

  // In IDLE the splitter looks at the incoming command so the first burst size
  // is ready on entry to ADDR; afterwards it tracks the updated addr/remaining.
  assign w_split_page = (r_state == ST_IDLE) ? w_cmd_addr_al[AXI_BOUNDARY_BITS-1:0]
                                             : r_addr[AXI_BOUNDARY_BITS-1:0];
  assign w_split_rem  = (r_state == ST_IDLE) ? w_cmd_rem : r_remaining;

  axi_burst_splitter #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .REM_WIDTH  (REM_WIDTH)
  ) u_splitter (
    .i_page_off  (w_split_page),
    .i_remaining (w_split_rem),
    .o_beats     (w_beats)
  );

  // Address wraps naturally modulo 2^ADDR_WIDTH
  assign w_addr_step = ADDR_WIDTH'(r_beats) << SIZE_LOG;

  // W channel is a straight passthrough of the stream, opened only in DATA;
  // m_wvalid depends on s_tvalid and the registered state, never on m_wready.
  assign w_in_data = (r_state == ST_DATA);
  assign w_w_fire  = w_in_data && s_tvalid && m_wready;

  assign m_wdata   = s_tdata;
  assign m_wstrb   = '1;
  assign m_wvalid  = w_in_data && s_tvalid;
  assign s_tready  = w_in_data && m_wready;
  assign m_wlast   = w_in_data && (r_cnt == 8'd0);

  assign m_awid    = ID_WIDTH'(AXI_ID);
  assign m_awaddr  = r_addr;
  assign m_awlen   = r_awlen;
  assign m_awsize  = 3'(SIZE_LOG);
  assign m_awburst = AXI_BURST_INCR;
  assign m_awvalid = r_awvalid;
  assign m_bready  = r_bready;
  assign cmd_ready = r_cmd_ready;
  assign done      = r_done;
  assign error     = r_error;

  // Write responses are matched by order; the returned ID carries no information
  assign w_unused  = ^m_bid;

  // Command / burst sequencing: IDLE -> ADDR -> DATA -> RESP -> (ADDR | IDLE)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_awlen     <= '0;
      r_cnt       <= '0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= w_cmd_addr_al;
            r_remaining <= w_cmd_rem;
            r_beats     <= w_beats;
            r_awlen     <= 8'(w_beats - 9'd1);
            r_error     <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b1;
            r_state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // AW fields are registers and stay put until the slave takes them
          if (m_awready) begin
            r_awvalid <= 1'b0;
            r_cnt     <= r_awlen;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_fire) begin
            if (r_cnt == 8'd0) begin
              r_addr      <= r_addr + w_addr_step;
              r_remaining <= r_remaining - REM_WIDTH'(r_beats);
              r_bready    <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (m_bvalid) begin
            r_bready <= 1'b0;
            // An error is recorded but the rest of the command still runs
            if (m_bresp != AXI_RESP_OKAY) begin
              r_error <= 1'b1;
            end
            if (r_remaining == '0) begin
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_beats   <= w_beats;
              r_awlen   <= 8'(w_beats - 9'd1);
              r_awvalid <= 1'b1;
              r_state   <= ST_ADDR;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_wr_master.sv
// tb/tb_axi_stream_wr_master.sv - self-checking bench with stream source, AXI RAM slave and burst model
module tb_axi_stream_wr_master;
  import axi_stream_wr_master_pkg::*;

  localparam int MAXB = 16;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          idx;
    int          cnt;
  } burst_t;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          err_burst;
    int          exp_bursts;
    int          exp_len0;
    bit          exp_error;
    int          seed;
    bit          poke;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [3:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        done, error;

  axi_stream_wr_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .done(done), .error(error)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bench-side state shared between the slave/source process and the main test
  logic [31:0] src_q[$];
  burst_t      pend_q[$];
  logic [1:0]  bq[$];
  logic [31:0] aw_log_addr[$];
  int          aw_log_len[$];
  logic [31:0] w_log[$];
  logic [31:0] mem [logic [31:0]];
  int          cyc = 0, done_cnt = 0, aw_total = 0, err_abs = -1, last_b_cyc = -10;
  bit          bp_en = 1'b0;
  bit          t_acc, b_acc, aw_wait;
  logic [31:0] aw_hold_addr;
  logic [7:0]  aw_hold_len;
  burst_t      cur_b;
  logic [31:0] wa;

  // Reference model: split a command into bursts using the plain rules
  logic [31:0] exp_aw_addr[$];
  int          exp_aw_len[$];

  task automatic model_bursts(input logic [31:0] addr, input int len);
    int rem, room, b;
    logic [31:0] a;
    rem = len + 1;
    a = addr & ~32'h3;
    exp_aw_addr.delete();
    exp_aw_len.delete();
    while (rem > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 4;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(b - 1);
      a = a + 32'(b * 4);
      rem = rem - b;
    end
  endtask

  // Stream source and AXI RAM slave: drive on negedge, sample handshakes 1 ns later
  initial begin
    s_tvalid = 0; s_tdata = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 0; m_bresp = 0; m_bid = 0;
    t_acc = 0; b_acc = 0; aw_wait = 0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        s_tvalid = 0; m_bvalid = 0; m_awready = 0; m_wready = 0;
        src_q.delete(); pend_q.delete(); bq.delete();
        t_acc = 0; b_acc = 0; aw_wait = 0;
      end else begin
        if (t_acc) s_tvalid = 0;
        if (b_acc) m_bvalid = 0;
        t_acc = 0; b_acc = 0;
        if (!s_tvalid && src_q.size() > 0 && (!bp_en || $urandom_range(0, 3) != 0)) s_tvalid = 1;
        s_tdata = (src_q.size() > 0) ? src_q[0] : 32'h0;
        m_awready = bp_en ? ($urandom_range(0, 2) == 0) : 1'b1;
        m_wready  = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!m_bvalid && bq.size() > 0 && (!bp_en || $urandom_range(0, 2) == 0)) begin
          m_bvalid = 1;
          m_bresp  = bq[0];
        end
        #1;
        if (aw_wait) begin
          check_eq("aw_hold_valid", m_awvalid, 1);
          check_eq("aw_hold_addr", m_awaddr, aw_hold_addr);
          check_eq("aw_hold_len", m_awlen, aw_hold_len);
        end
        aw_wait = m_awvalid && !m_awready;
        aw_hold_addr = m_awaddr;
        aw_hold_len = m_awlen;
        if (m_wvalid) check_eq("w_after_aw", pend_q.size() > 0, 1);
        if (m_wvalid && m_wready && pend_q.size() > 0) begin
          cur_b = pend_q[0];
          wa = cur_b.addr + 32'(cur_b.cnt * 4);
          mem[wa] = m_wdata;
          w_log.push_back(m_wdata);
          check_eq("wlast", m_wlast, cur_b.cnt == cur_b.len);
          check_eq("wstrb", m_wstrb, 4'hF);
          cur_b.cnt++;
          pend_q[0] = cur_b;
          if (cur_b.cnt > cur_b.len) begin
            void'(pend_q.pop_front());
            bq.push_back((cur_b.idx == err_abs) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
          end
        end
        if (m_awvalid && m_awready) begin
          check_eq("awsize", m_awsize, 2);
          check_eq("awburst", m_awburst, 1);
          check_eq("awid", m_awid, 0);
          aw_log_addr.push_back(m_awaddr);
          aw_log_len.push_back(int'(m_awlen));
          pend_q.push_back('{m_awaddr, int'(m_awlen), aw_total, 0});
          aw_total++;
        end
        if (s_tvalid && s_tready) begin
          check_eq("wdata_pass", m_wdata, s_tdata);
          void'(src_q.pop_front());
          t_acc = 1;
        end
        if (m_bvalid && m_bready) begin
          void'(bq.pop_front());
          b_acc = 1;
          last_b_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          check_eq("done_latency", cyc - last_b_cyc, 1);
        end
      end
    end
  end

  task automatic wait_cmd_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge aclk); #2;
      n++;
    end
    check_eq("cmd_ready_idle", cmd_ready, 1);
  endtask

  task automatic run_cmd(input vec_t v);
    logic [31:0] data_q[$];
    logic [31:0] d, a;
    int aw_base, w_base, done_base, n, k, na, nw;
    model_bursts(v.addr, v.len);
    for (int i = 0; i <= v.len; i++) begin
      d = (v.seed != 0) ? 32'(v.seed + i) : $urandom;
      data_q.push_back(d);
    end
    wait_cmd_ready();
    aw_base = aw_log_addr.size();
    w_base = w_log.size();
    done_base = done_cnt;
    err_abs = (v.err_burst < 0) ? -1 : aw_total + v.err_burst;
    foreach (data_q[i]) src_q.push_back(data_q[i]);
    cmd_addr = v.addr;
    cmd_len = 16'(v.len);
    cmd_valid = 1;
    @(negedge aclk); #2;
    check_eq("cmd_ready_drop", cmd_ready, 0);
    check_eq("error_clear", error, 0);
    if (v.poke) begin
      cmd_addr = 32'hDEAD_0000;
      cmd_len = 16'd5;
      for (int i = 0; i < 10; i++) begin
        @(negedge aclk); #2;
        check_eq("busy_cmd_ready", cmd_ready, 0);
      end
    end
    cmd_valid = 0;
    n = 0;
    while (done_cnt == done_base && n < 5000) begin
      @(negedge aclk); #2;
      n++;
    end
    check_eq("done_seen", done_cnt != done_base, 1);
    check_eq("error", error, v.exp_error);
    repeat (4) @(negedge aclk);
    #2;
    check_eq("done_once", done_cnt - done_base, 1);
    check_eq("error_held", error, v.exp_error);
    na = aw_log_addr.size() - aw_base;
    check_eq("aw_count", na, exp_aw_addr.size());
    if (v.exp_bursts >= 0) check_eq("aw_count_tbl", na, v.exp_bursts);
    if (v.exp_len0 >= 0 && na > 0) check_eq("awlen0_tbl", aw_log_len[aw_base], v.exp_len0);
    for (int i = 0; i < na && i < exp_aw_addr.size(); i++) begin
      check_eq("awaddr", aw_log_addr[aw_base + i], exp_aw_addr[i]);
      check_eq("awlen", aw_log_len[aw_base + i], exp_aw_len[i]);
    end
    nw = w_log.size() - w_base;
    check_eq("w_count", nw, data_q.size());
    for (int i = 0; i < nw && i < data_q.size(); i++)
      check_eq("w_order", w_log[w_base + i], data_q[i]);
    k = 0;
    for (int i = 0; i < exp_aw_addr.size(); i++) begin
      for (int j = 0; j <= exp_aw_len[i]; j++) begin
        a = exp_aw_addr[i] + 32'(j * 4);
        check_eq("mem", mem.exists(a) ? mem[a] : ~data_q[k], data_q[k]);
        k++;
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    logic [31:0] ra, w_base;
    int total, n;

    vecs[0] = '{32'h0000_0100, 3,  -1, 1, 3,  1'b0, 32'hA0, 1'b0};
    vecs[1] = '{32'h0000_0000, 39, -1, 3, 15, 1'b0, 0,      1'b1};
    vecs[2] = '{32'h0000_0FF8, 3,  -1, 2, 1,  1'b0, 0,      1'b0};
    vecs[3] = '{32'h0000_02F0, 19,  1, 2, 15, 1'b1, 0,      1'b0};
    vecs[4] = '{32'h0000_1FFC, 0,  -1, 1, 0,  1'b0, 0,      1'b0};
    vecs[5] = '{32'hFFFF_FFF0, 7,  -1, 2, 3,  1'b0, 0,      1'b0};

    aresetn = 1; cmd_valid = 0; cmd_addr = 0; cmd_len = 0;
    #2 aresetn = 0;
    repeat (3) @(negedge aclk);
    #2;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_awvalid", m_awvalid, 0);
    check_eq("rst_bready", m_bready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_tready", s_tready, 0);
    check_eq("rst_wvalid", m_wvalid, 0);
    aresetn = 1;
    repeat (2) @(negedge aclk);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // Reset in the middle of a DATA phase
    wait_cmd_ready();
    w_base = w_log.size();
    for (int i = 0; i < 32; i++) src_q.push_back($urandom);
    cmd_addr = 32'h400; cmd_len = 16'd31; cmd_valid = 1;
    @(negedge aclk); #2;
    cmd_valid = 0;
    n = 0;
    while (w_log.size() < w_base + 3 && n < 200) begin
      @(negedge aclk); #2;
      n++;
    end
    check_eq("rst_reach_data", w_log.size() >= w_base + 3, 1);
    aresetn = 0;
    #1;
    check_eq("mid_rst_cmd_ready", cmd_ready, 1);
    check_eq("mid_rst_awvalid", m_awvalid, 0);
    check_eq("mid_rst_wvalid", m_wvalid, 0);
    check_eq("mid_rst_bready", m_bready, 0);
    check_eq("mid_rst_tready", s_tready, 0);
    repeat (3) @(negedge aclk);
    #2;
    aresetn = 1;
    rv = '{32'h0000_0400, 7, -1, 1, 7, 1'b0, 0, 1'b0};
    run_cmd(rv);

    // Randomised traffic with stream gaps and slave backpressure
    bp_en = 1;
    total = 0;
    while (total < 100) begin
      ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFC0 + 12'($urandom_range(0, 15) * 4);
      rv = '{ra, int'($urandom_range(0, 40)), -1, -1, -1, 1'b0, 0, 1'b0};
      run_cmd(rv);
      total += rv.len + 1;
    end
    bp_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
